// File: rtl/port_aggregate_arbiter.sv
// port_aggregate_arbiter: per-port store-and-forward FIFOs merged round-robin into one tagged packet stream
module port_aggregate_arbiter #(
  parameter int PORT_NUM      = 4,
  parameter int DATA_WIDTH    = 134,
  parameter int TIME_WIDTH    = 19,
  parameter int FIFO_DEPTH    = 128,
  parameter int PORT_ID_WIDTH = 2
) (
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  input  logic [PORT_NUM-1:0]              iv_data_wr,
  input  logic [PORT_NUM*DATA_WIDTH-1:0]   iv_data,
  input  logic [PORT_NUM*TIME_WIDTH-1:0]   iv_relative_time,
  input  logic                             i_ready,
  output logic [DATA_WIDTH-1:0]            ov_data,
  output logic [TIME_WIDTH-1:0]            ov_relative_time,
  output logic [PORT_ID_WIDTH-1:0]         ov_port_id,
  output logic                             o_data_wr,
  output logic [PORT_NUM-1:0]              ov_drop_pulse,
  output logic [PORT_NUM-1:0]              ov_malform_pulse
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = TIME_WIDTH + DATA_WIDTH;
  localparam logic [AW:0] DEPTH = (AW+1)'(FIFO_DEPTH);
  typedef enum logic {IDLE, SEND} state_t;
  state_t state, state_nxt;
  logic [EW-1:0] mem [PORT_NUM][FIFO_DEPTH];
  logic [AW:0] wp [PORT_NUM];
  logic [AW:0] cp [PORT_NUM];
  logic [AW:0] rp [PORT_NUM];
  logic [AW:0] base [PORT_NUM];
  logic [AW-1:0] pc [PORT_NUM];
  logic [PORT_NUM-1:0] open, drop, head, tail, full_h, full_b, store, commit;
  logic [PORT_ID_WIDTH-1:0] gnt, nxt_id;
  logic req_any, pop, pop_tail;
  logic [EW-1:0] rd_word;

  function automatic logic [PORT_ID_WIDTH-1:0] wrap(input int v);
    return PORT_ID_WIDTH'(v >= PORT_NUM ? v - PORT_NUM : v);
  endfunction

  // classify each port's word; a head restarts from the committed pointer when a packet is open
  always_comb begin
    for (int p = 0; p < PORT_NUM; p++) begin
      head[p]   = iv_data[p*DATA_WIDTH+DATA_WIDTH-2 +: 2] == 2'b01;
      tail[p]   = iv_data[p*DATA_WIDTH+DATA_WIDTH-2 +: 2] == 2'b10;
      base[p]   = open[p] ? cp[p] : wp[p];
      full_h[p] = (base[p] - rp[p]) == DEPTH;
      full_b[p] = (wp[p] - rp[p]) == DEPTH;
      store[p]  = iv_data_wr[p] && (head[p] ? !full_h[p] : open[p] && !full_b[p]);
      commit[p] = iv_data_wr[p] && tail[p] && open[p] && !full_b[p];
    end
  end

  // per-port pointers, packet counters, packet-open and discard-until-head flags, event pulses
  always_ff @(posedge i_clk) begin
    for (int p = 0; p < PORT_NUM; p++) begin
      if (!i_rst_n) begin
        wp[p] <= '0;
        cp[p] <= '0;
        rp[p] <= '0;
        pc[p] <= '0;
        open[p] <= 1'b0;
        drop[p] <= 1'b0;
        ov_drop_pulse[p] <= 1'b0;
        ov_malform_pulse[p] <= 1'b0;
      end else begin
        ov_drop_pulse[p] <= iv_data_wr[p] && (head[p] ? open[p] || full_h[p] : open[p] && full_b[p]);
        ov_malform_pulse[p] <= iv_data_wr[p] && !head[p] && !open[p] && !drop[p];
        if (store[p]) wp[p] <= (head[p] ? base[p] : wp[p]) + 1'b1;
        else if (iv_data_wr[p] && (head[p] || open[p])) wp[p] <= cp[p];
        if (commit[p]) cp[p] <= wp[p] + 1'b1;
        if (iv_data_wr[p]) open[p] <= head[p] ? !full_h[p] : open[p] && !full_b[p] && !tail[p];
        if (iv_data_wr[p]) drop[p] <= head[p] ? full_h[p] : drop[p] || (open[p] && full_b[p]);
        if (pop && gnt == PORT_ID_WIDTH'(p)) rp[p] <= rp[p] + 1'b1;
        pc[p] <= pc[p] + AW'(commit[p]) - AW'(pop_tail && gnt == PORT_ID_WIDTH'(p));
      end
    end
  end

  // word storage, entry = {time, data}
  always_ff @(posedge i_clk) begin
    for (int p = 0; p < PORT_NUM; p++)
      if (store[p]) mem[p][head[p] ? base[p][AW-1:0] : wp[p][AW-1:0]] <= {iv_relative_time[p*TIME_WIDTH +: TIME_WIDTH], iv_data[p*DATA_WIDTH +: DATA_WIDTH]};
  end

  // round-robin scan for a committed packet starting after the last granted port
  always_comb begin
    req_any = 1'b0;
    nxt_id = gnt;
    for (int k = PORT_NUM-1; k >= 0; k--)
      if (pc[wrap(int'(gnt) + 1 + k)] != '0) begin
        req_any = 1'b1;
        nxt_id = wrap(int'(gnt) + 1 + k);
      end
  end

  // state register
  always_ff @(posedge i_clk) state <= !i_rst_n ? IDLE : state_nxt;

  // next state: grant costs one idle cycle, popping the tail releases the grant
  always_comb state_nxt = state == IDLE ? (req_any ? SEND : IDLE) : (pop_tail ? IDLE : SEND);

  // pop control for the granted port
  always_comb begin
    rd_word = mem[gnt][rp[gnt][AW-1:0]];
    pop = state == SEND && i_ready && rp[gnt] != cp[gnt];
    pop_tail = pop && rd_word[DATA_WIDTH-1 -: 2] == 2'b10;
  end

  // granted port doubles as the round-robin pointer; reset makes the first scan start at port 0
  always_ff @(posedge i_clk)
    if (!i_rst_n) gnt <= PORT_ID_WIDTH'(PORT_NUM-1);
    else if (state == IDLE && req_any) gnt <= nxt_id;

  // registered output stage; time is captured from the head word and held for the packet
  always_ff @(posedge i_clk)
    if (!i_rst_n) begin
      o_data_wr <= 1'b0;
      ov_data <= '0;
      ov_relative_time <= '0;
      ov_port_id <= '0;
    end else begin
      o_data_wr <= pop;
      if (pop) ov_data <= rd_word[DATA_WIDTH-1:0];
      if (pop) ov_port_id <= gnt;
      if (pop && rd_word[DATA_WIDTH-1 -: 2] == 2'b01) ov_relative_time <= rd_word[EW-1 -: TIME_WIDTH];
    end
endmodule

// File: tb/tb_port_aggregate_arbiter.sv
// tb_port_aggregate_arbiter: vector table plus corner sequences, outputs checked through an expected-word queue
module tb_port_aggregate_arbiter;
  localparam int N = 4, DW = 134, TW = 19, D = 8;
  typedef logic [7:0][1:0] tags_t;
  typedef struct {logic [DW-1:0] d; logic [TW-1:0] t; logic [1:0] p;} exp_t;
  typedef struct {int port; int n; tags_t tags; logic [TW-1:0] tm; int first; int drops; int mals;} vec_t;
  logic clk = 0, rst_n = 0, ready = 1;
  logic [N-1:0] wr = '0;
  logic [N*DW-1:0] data = '0;
  logic [N*TW-1:0] tm = '0;
  logic [DW-1:0] ov_data;
  logic [TW-1:0] ov_relative_time;
  logic [1:0] ov_port_id;
  logic o_data_wr;
  logic [N-1:0] ov_drop_pulse, ov_malform_pulse;
  exp_t q[$];
  exp_t e;
  int checks = 0, errors = 0, out_cnt = 0;
  int drop_cnt[N], mal_cnt[N];

  port_aggregate_arbiter #(.PORT_NUM(N), .DATA_WIDTH(DW), .TIME_WIDTH(TW), .FIFO_DEPTH(D), .PORT_ID_WIDTH(2)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .iv_data_wr(wr), .iv_data(data), .iv_relative_time(tm), .i_ready(ready),
    .ov_data(ov_data), .ov_relative_time(ov_relative_time), .ov_port_id(ov_port_id), .o_data_wr(o_data_wr),
    .ov_drop_pulse(ov_drop_pulse), .ov_malform_pulse(ov_malform_pulse));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    for (int p = 0; p < N; p++) begin
      drop_cnt[p] += int'(ov_drop_pulse[p]);
      mal_cnt[p] += int'(ov_malform_pulse[p]);
    end
    if (o_data_wr) begin
      out_cnt++;
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_word got d=%h p=%0d", ov_data, ov_port_id);
      end else begin
        e = q.pop_front();
        if (ov_data !== e.d || ov_relative_time !== e.t || ov_port_id !== e.p) begin
          errors++;
          $display("FAIL word got d=%h t=%h p=%0d exp d=%h t=%h p=%0d", ov_data, ov_relative_time, ov_port_id, e.d, e.t, e.p);
        end
      end
    end
  end

  function automatic logic [DW-1:0] mk(int p, int k, int i, logic [1:0] tag);
    return {tag, 100'(0), 8'(p), 8'(k), 16'(i)};
  endfunction

  function automatic tags_t std_tags(int n);
    tags_t t = '0;
    for (int i = 0; i < n; i++) t[i] = i == 0 ? 2'b01 : i == n-1 ? 2'b10 : 2'b11;
    return t;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    wr = '0;
  endtask

  task automatic put(int p, logic [DW-1:0] w, logic [TW-1:0] t);
    wr[p] = 1'b1;
    data[p*DW +: DW] = w;
    tm[p*TW +: TW] = t;
  endtask

  task automatic expect_words(int p, int k, int n, tags_t tg, logic [TW-1:0] t0, int first);
    if (first >= 0)
      for (int i = first; i < n; i++) q.push_back('{mk(p, k, i, tg[i]), t0 + TW'(first), 2'(p)});
  endtask

  task automatic drive(int p, int k, int n, tags_t tg, logic [TW-1:0] t0);
    for (int i = 0; i < n; i++) begin
      put(p, mk(p, k, i, tg[i]), t0 + TW'(i));
      tick();
    end
  endtask

  task automatic check(string name, logic [DW-1:0] got, logic [DW-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", name, got, want);
    end
  endtask

  task automatic drain(int budget);
    for (int c = 0; c < budget && q.size() != 0; c++) tick();
    check("drain", DW'(q.size()), '0);
    repeat (4) tick();
  endtask

  task automatic check_idle_outputs(string tag);
    check({tag, "_data"}, ov_data, '0);
    check({tag, "_time"}, DW'(ov_relative_time), '0);
    check({tag, "_port"}, DW'(ov_port_id), '0);
    check({tag, "_wr"}, DW'(o_data_wr), '0);
    check({tag, "_pulses"}, DW'({ov_drop_pulse, ov_malform_pulse}), '0);
  endtask

  task automatic do_reset();
    rst_n = 0;
    tick();
    tick();
    rst_n = 1;
    q.delete();
  endtask

  initial begin
    vec_t v[7];
    tags_t tg;
    logic [17:0] pat;
    int d0, m0, o0;
    v[0] = '{1, 2, std_tags(2), 19'h100, 0, 0, 0};
    v[1] = '{2, 5, tags_t'({6'b0, 2'b10, 2'b11, 2'b11, 2'b00, 2'b01}), 19'h200, 0, 0, 0};
    v[2] = '{3, 8, std_tags(8), 19'h300, 0, 0, 0};
    v[3] = '{2, 5, tags_t'({6'b0, 2'b10, 2'b11, 2'b01, 2'b11, 2'b01}), 19'h400, 2, 1, 0};
    v[4] = '{3, 2, tags_t'({12'b0, 2'b10, 2'b11}), 19'h500, -1, 0, 2};
    v[5] = '{0, 3, tags_t'({10'b0, 2'b10, 2'b01, 2'b10}), 19'h600, 1, 0, 1};
    v[6] = '{1, 4, tags_t'({8'b0, 2'b10, 2'b11, 2'b01, 2'b01}), 19'h700, 1, 1, 0};
    tick();
    tick();
    @(negedge clk);
    check_idle_outputs("reset");
    rst_n = 1;
    tick();
    expect_words(0, 1, 4, std_tags(4), 19'h1234, 0);
    drive(0, 1, 4, std_tags(4), 19'h1234);
    pat = '0;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      pat[k] = o_data_wr;
    end
    check("s1_wr_timing", DW'(pat[6:0]), DW'(7'b0111100));
    drain(20);
    do_reset();
    tg = std_tags(3);
    for (int p = 0; p < N; p++) expect_words(p, 2, 3, tg, TW'(19'h2000 + p), 0);
    for (int i = 0; i < 3; i++) begin
      for (int p = 0; p < N; p++) put(p, mk(p, 2, i, tg[i]), TW'(19'h2000 + p + i));
      tick();
    end
    for (int k = 0; k < 18; k++) begin
      @(negedge clk);
      pat[k] = o_data_wr;
    end
    check("s2_rr_timing", DW'(pat), DW'(18'b011101110111011100));
    drain(20);
    ready = 0;
    d0 = drop_cnt[1];
    m0 = mal_cnt[1];
    o0 = out_cnt;
    expect_words(1, 3, 6, std_tags(6), 19'h3000, 0);
    drive(1, 3, 6, std_tags(6), 19'h3000);
    tg = std_tags(5);
    for (int i = 0; i < 5; i++) begin
      put(1, mk(1, 4, i, tg[i]), TW'(19'h3100 + i));
      tick();
      @(negedge clk);
      check($sformatf("s3_drop_w%0d", i), DW'(ov_drop_pulse[1]), DW'(i == 2));
    end
    check("s3_hold", DW'(out_cnt - o0), '0);
    check("s3_drop_cnt", DW'(drop_cnt[1] - d0), DW'(1));
    check("s3_mal_cnt", DW'(mal_cnt[1] - m0), '0);
    ready = 1;
    drain(40);
    for (int r = 0; r < 7; r++) begin
      d0 = drop_cnt[v[r].port];
      m0 = mal_cnt[v[r].port];
      expect_words(v[r].port, 10 + r, v[r].n, v[r].tags, v[r].tm, v[r].first);
      drive(v[r].port, 10 + r, v[r].n, v[r].tags, v[r].tm);
      drain(60);
      check($sformatf("vec%0d_drop", r), DW'(drop_cnt[v[r].port] - d0), DW'(v[r].drops));
      check($sformatf("vec%0d_mal", r), DW'(mal_cnt[v[r].port] - m0), DW'(v[r].mals));
    end
    ready = 0;
    o0 = out_cnt;
    expect_words(0, 5, 5, std_tags(5), 19'h4000, 0);
    drive(0, 5, 5, std_tags(5), 19'h4000);
    for (int k = 0; k < 20; k++) begin
      ready = (k % 2) == 1;
      tick();
      @(negedge clk);
      check("s4_gate", DW'(o_data_wr && (k % 2) == 0), '0);
    end
    ready = 1;
    drain(20);
    check("s4_count", DW'(out_cnt - o0), DW'(5));
    expect_words(0, 6, 2, std_tags(8), 19'h5000, 0);
    drive(0, 6, 8, std_tags(8), 19'h5000);
    tick();
    tick();
    tick();
    rst_n = 0;
    tick();
    @(negedge clk);
    check_idle_outputs("s5_reset");
    check("s5_words_before_reset", DW'(q.size()), '0);
    rst_n = 1;
    q.delete();
    tick();
    expect_words(0, 7, 4, std_tags(4), 19'h5100, 0);
    drive(0, 7, 4, std_tags(4), 19'h5100);
    drain(20);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL timeout got running exp finished");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/port_aggregate_arbiter.md
# port_aggregate_arbiter

Parametrised N-port packet aggregator between the per-port interface_input_process instances and the um user module. It buffers each port's 134-bit word stream in a per-port store-and-forward FIFO, discards overflowing and malformed packets atomically, and merges complete packets round-robin into one stream tagged with the source port. It replaces the fixed four-way parallel port-to-um wiring and allows any port count.

## Interface
- PORT_NUM, 4: number of input ports (≥2)
- DATA_WIDTH, 134: word width; bits [133:132] are the word tag
- TIME_WIDTH, 19: relative-time width
- FIFO_DEPTH, 128: words per port FIFO, power of 2, ≥ max packet length
- PORT_ID_WIDTH, 2: ceil(log2(PORT_NUM))

- i_clk  in  1  single clock (core clock domain)
- i_rst_n  in  1  synchronous, active-low reset
- iv_data_wr  in  PORT_NUM  per-port word strobe
- iv_data  in  PORT_NUM*DATA_WIDTH  port p word at [p*DATA_WIDTH +: DATA_WIDTH]
- iv_relative_time  in  PORT_NUM*TIME_WIDTH  port p time, meaningful on head word only
- i_ready  in  1  downstream accepts a word this cycle
- ov_data  out  DATA_WIDTH  merged word
- ov_relative_time  out  TIME_WIDTH  time stored with the head word, held for the whole packet
- ov_port_id  out  PORT_ID_WIDTH  source port of current packet
- o_data_wr  out  1  ov_data valid
- ov_drop_pulse  out  PORT_NUM  one-cycle pulse per discarded packet (overflow or restart)
- ov_malform_pulse  out  PORT_NUM  one-cycle pulse per orphan body/tail word

## Operation
- Tags: 2'b01 head, 2'b11 body, 2'b10 tail, 2'b00 treated as body. Packets are ≥2 words (head…tail).
- Per port: write pointer wp, committed pointer cp, read pointer rp (each log2(FIFO_DEPTH)+1 bits, wrap modulo 2·FIFO_DEPTH), packet counter pc (log2(FIFO_DEPTH) bits), open flag. Entry = {time, data}.
- Write side per port: head → open=1, store at wp. Body/tail with open=1 → store; tail → cp←wp+1, pc+1, open=0. Body/tail with open=0 → discard, ov_malform_pulse.
- Overflow: word arrives with wp−rp == FIFO_DEPTH → wp←cp, open stays 0, discard until next head, ov_drop_pulse once. Head arriving while open=1 → wp←cp, then store the new head normally, ov_drop_pulse.
- Reader sees only words below cp; a partial packet is never emitted.
- FSM: IDLE → scan ports starting at rr+1 (mod PORT_NUM) for pc≠0; grant first found, latch id, rr←id, go SEND. SEND: each cycle with i_ready=1 pop one word of the granted port; on popping tail, pc−1, return IDLE. IDLE with no request stays IDLE.
- Simultaneous commit and pop-of-tail on one port: pc unchanged. All ports write independently of the reader every cycle.

## Timing
- Reset (sync, i_rst_n=0 at edge): all pointers, pc, open, FSM=IDLE, rr=PORT_NUM−1 (first scan starts at port 0); ov_data=0, ov_relative_time=0, ov_port_id=0, o_data_wr=0, pulses=0. Reset mid-packet drops everything buffered, no pulse.
- Outputs registered: pop at edge n → o_data_wr=1 with word after edge n; i_ready=0 → o_data_wr=0 next cycle, word held in FIFO.
- Arbitration costs exactly 1 IDLE cycle per packet; min latency tail-written-to-head-out = 2 cycles.
- Sustained throughput: L-word packet takes L+1 cycles.
- Pulses asserted the cycle after the triggering word's edge, width 1.

## Test plan
- Port 0 sends 4-word packet (head time=0x1234), i_ready=1 → o_data_wr 4 consecutive cycles starting 2 cycles after tail, ov_port_id=0, ov_relative_time=0x1234 throughout.
- Ports 0–3 each commit one 3-word packet in the same cycle → output order 0,1,2,3, each preceded by one idle cycle, 16 cycles total.
- FIFO_DEPTH=8, port 1 holds a 6-word packet unread (i_ready=0), sends 5-word packet → ov_drop_pulse[1] on 3rd word, later only the 6-word packet emerges.
- Port 2: head, body, head, body, tail → one drop pulse, only the second 3-word packet output.
- Port 3: body then tail with no head → two ov_malform_pulse[3], no output; i_ready toggled 1/0 during a 5-word packet → no word lost or duplicated.
- Assert i_rst_n=0 mid-SEND → next cycle all outputs 0; after release a new port-0 packet emerges intact.
